// File: rtl/arc_mem_pkg.sv
// Shared definitions for the ARC main-memory bus controller: word size,
// default geometry, FSM state encoding and the request address check.
package arc_mem_pkg;

    localparam int unsigned ARC_WORD        = 32;
    localparam int unsigned DEF_AW          = 10;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_FAULT  = 2'd3
    } mm_state_t;

    // A byte address is unusable when it is not word aligned or lies beyond 2**aw words.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mm_wait_counter.sv
// 4-bit loadable down-counter that paces the SRAM wait states; saturates at zero.
module mm_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mm_bus_ctrl.sv
// Memory bus controller: turns held rd/wr strobes into a fixed-latency access
// on a synchronous word SRAM and answers with a one-cycle ack (plus err on faults).
module mm_bus_ctrl
    import arc_mem_pkg::*;
#(
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = ARC_WORD,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [31:0]   address,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          ack,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    mm_state_t state;
    logic      dir_wr;
    logic      req;
    logic      bad_req;
    logic      accept;
    logic      cnt_zero;

    assign req     = rd || wr;
    assign bad_req = (rd && wr) || addr_fault(address, AW);
    assign accept  = (state == ST_IDLE) && req && !bad_req;

    mm_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (state == ST_ACCESS),
        .zero     (cnt_zero)
    );

    // mem_addr/mem_wdata double as the request latches, so later bus changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dir_wr    <= 1'b0;
            data_out  <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && bad_req) begin
                        state <= ST_FAULT;
                        ack   <= 1'b1;
                        err   <= 1'b1;
                    end else if (req) begin
                        state     <= ST_ACCESS;
                        mem_en    <= 1'b1;
                        mem_we    <= wr;
                        mem_addr  <= address[AW+1:2];
                        mem_wdata <= data_in;
                        dir_wr    <= wr;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state  <= ST_DONE;
                        ack    <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!dir_wr) begin
                            data_out <= mem_rdata;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_bus_ctrl.sv
// Scoreboard bench for mm_bus_ctrl: stimulus queues expected acks, a monitor
// pops and compares them; a second WAIT_CYCLES=0 instance checks minimum latency.
module tb_mm_bus_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          ack_cyc;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rd, wr;
    logic [31:0] address, data_in, data_out;
    logic        ack, err, mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        rd0, wr0;
    logic [31:0] address0, data_in0, data_out0;
    logic        ack0, err0, mem_en0, mem_we0;
    logic [9:0]  mem_addr0;
    logic [31:0] mem_wdata0, mem_rdata0;

    logic [31:0] mem  [0:1023];
    logic [31:0] mem0 [0:1023];

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   en_total, we_total, en0_total;

    mm_bus_ctrl #(.AW(10), .DW(32), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .address(address), .data_in(data_in),
        .data_out(data_out), .ack(ack), .err(err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mm_bus_ctrl #(.AW(10), .DW(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .rd(rd0), .wr(wr0), .address(address0), .data_in(data_in0),
        .data_out(data_out0), .ack(ack0), .err(err0), .mem_en(mem_en0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Synchronous read-first SRAM models.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0BAD_0000 + i;
        mem[5]  = 32'hDEAD_BEEF;
        mem[16] = 32'h1111_0000;
        mem[17] = 32'h2222_0001;
        mem[18] = 32'h3333_0002;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem0[i] = 32'h0C0C_0000 + i;
        forever begin
            @(posedge clk);
            if (mem_en0) begin
                if (mem_we0) mem0[mem_addr0] <= mem_wdata0;
                mem_rdata0 <= mem0[mem_addr0];
            end
        end
    end

    initial begin
        en_total  = 0;
        we_total  = 0;
        en0_total = 0;
        forever begin
            @(negedge clk);
            if (mem_en)  en_total++;
            if (mem_we)  we_total++;
            if (mem_en0) en0_total++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every ack is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("t%0d_err", e.id), {31'd0, err}, {31'd0, e.err});
                    chk($sformatf("t%0d_data_out", e.id), data_out, e.data);
                    chk($sformatf("t%0d_ack_cycle", e.id), cyc, e.ack_cyc);
                end
            end
        end
    end

    task automatic wait_ack(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ack) chk($sformatf("t%0d_ack_timeout", id), 32'd0, 32'd1);
    endtask

    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic [31:0] exp_d, input int lat, input int id,
                         output int en_n, output int we_n);
        int en_s, we_s;
        @(posedge clk);
        #1;
        en_s = en_total;
        we_s = we_total;
        rd = r; wr = w; address = a; data_in = d;
        sb.push_back('{e, exp_d, cyc + lat, id});
        wait_ack(id);
        rd = 1'b0; wr = 1'b0;
        en_n = en_total - en_s;
        we_n = we_total - we_s;
    endtask

    initial begin
        int en_n, we_n, c, n, en0_s;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; address = '0; data_in = '0;
        rd0 = 1'b0; wr0 = 1'b0; address0 = '0; data_in0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Plain read, write, read-back.
        issue(1, 0, 32'h14, 32'h0, 0, 32'hDEAD_BEEF, 4, 1, en_n, we_n);
        chk("t1_mem_en_cycles", en_n, 3);
        issue(0, 1, 32'h20, 32'h1234_5678, 0, 32'hDEAD_BEEF, 4, 2, en_n, we_n);
        chk("t2_mem_we_cycles", we_n, 3);
        chk("t2_mem_en_cycles", en_n, 3);
        issue(1, 0, 32'h20, 32'h0, 0, 32'h1234_5678, 4, 3, en_n, we_n);

        // Bus changes after acceptance must not reach the SRAM.
        @(posedge clk);
        #1;
        wr = 1'b1; address = 32'h24; data_in = 32'hA5A5_0001;
        sb.push_back('{1'b0, 32'h1234_5678, cyc + 4, 4});
        @(posedge clk);
        #1;
        address = 32'h28; data_in = 32'h5A5A_FFFF;
        wait_ack(4);
        wr = 1'b0;
        issue(1, 0, 32'h24, 32'h0, 0, 32'hA5A5_0001, 4, 5, en_n, we_n);

        // Faults: misaligned, out of range, rd and wr together.
        issue(1, 0, 32'h13, 32'h0, 1, 32'hA5A5_0001, 1, 6, en_n, we_n);
        chk("t6_mem_en_cycles", en_n, 0);
        issue(1, 0, 32'h1000, 32'h0, 1, 32'hA5A5_0001, 1, 7, en_n, we_n);
        chk("t7_mem_en_cycles", en_n, 0);
        issue(1, 1, 32'h14, 32'h0, 1, 32'hA5A5_0001, 1, 8, en_n, we_n);
        chk("t8_mem_en_cycles", en_n, 0);

        // Back-to-back reads with rd held, address switched on each ack.
        @(posedge clk);
        #1;
        rd = 1'b1; address = 32'h40;
        sb.push_back('{1'b0, 32'h1111_0000, cyc + 4, 9});
        wait_ack(9);
        address = 32'h44;
        sb.push_back('{1'b0, 32'h2222_0001, cyc + 5, 10});
        wait_ack(10);
        address = 32'h48;
        sb.push_back('{1'b0, 32'h3333_0002, cyc + 5, 11});
        wait_ack(11);
        rd = 1'b0;

        // Asynchronous reset in the middle of a write.
        @(posedge clk);
        #1;
        wr = 1'b1; address = 32'h30; data_in = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        chk("t12_mem_we_before_rst", {31'd0, mem_we}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t12_mem_en_async", {31'd0, mem_en}, 32'd0);
        chk("t12_mem_we_async", {31'd0, mem_we}, 32'd0);
        chk("t12_ack_async", {31'd0, ack}, 32'd0);
        chk("t12_data_out_async", data_out, 32'd0);
        wr = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        issue(1, 0, 32'h14, 32'h0, 0, 32'hDEAD_BEEF, 4, 13, en_n, we_n);
        chk("t13_mem_en_cycles", en_n, 3);

        // WAIT_CYCLES=0 instance: two-cycle latency, single enable cycle.
        @(posedge clk);
        #1;
        en0_s = en0_total;
        rd0 = 1'b1; address0 = 32'h14;
        c = cyc;
        n = 0;
        @(negedge clk);
        while (!ack0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w0_ack_seen", {31'd0, ack0}, 32'd1);
        chk("w0_ack_latency", cyc - c, 2);
        chk("w0_err", {31'd0, err0}, 32'd0);
        rd0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("w0_mem_en_cycles", en0_total - en0_s, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
